// File: rtl/sa_inst_decoder.sv
`default_nettype none
// ============================================================================
// Module   : sa_inst_decoder
// Purpose  : Instruction decoder and sequencer for the systolic array.
//            Accepts one {opcode, addra, addrb} word per valid/ready
//            handshake. Expands it into cycle-accurate strobes for the
//            unified buffer, weight buffer, data/weight FIFOs, MMU and
//            accumulator. Pulses done in the last execute cycle.
// Ports    : clk, reset          - clock, asynchronous active-high reset
//            inst_valid/ready    - instruction handshake
//            instruction         - [19:16] opcode, [15:8] addra, [7:0] addrb
//            busy, done, err     - status (err is sticky until reset)
//            read_ub, write_ub, read_wb, write_wb, write_acc
//                                - buffer strobes
//            data_fifo_en, weight_fifo_en, mm_en, acc_en, acc_mode
//                                - datapath enables
//            addr_a / addr_b     - write-side / read-side addresses
// Revision : 1.0 - initial release
// ============================================================================
module sa_inst_decoder #(
    parameter int OPCODE_BITS = 4,
    parameter int ADDR_BITS   = 8,
    parameter int INST_BITS   = 20,
    parameter int SA_SIZE     = 16,
    parameter int MM_LATENCY  = 18
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 inst_valid,
    input  logic [INST_BITS-1:0] instruction,
    output logic                 inst_ready,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic                 read_ub,
    output logic                 write_ub,
    output logic                 read_wb,
    output logic                 write_wb,
    output logic                 write_acc,
    output logic                 data_fifo_en,
    output logic                 weight_fifo_en,
    output logic                 mm_en,
    output logic                 acc_en,
    output logic                 acc_mode,
    output logic [ADDR_BITS-1:0] addr_a,
    output logic [ADDR_BITS-1:0] addr_b
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // The longest instruction is a matmul. Its last cycle index is
    // MM_LATENCY+SA_SIZE-1, so k never has to wrap inside an instruction.
    localparam int c_K_MAX  = MM_LATENCY + SA_SIZE - 1;
    localparam int c_K_BITS = (c_K_MAX > 0) ? $clog2(c_K_MAX + 1) : 1;

    localparam logic [c_K_BITS-1:0] c_K_SA      = c_K_BITS'(SA_SIZE);
    localparam logic [c_K_BITS-1:0] c_K_MM      = c_K_BITS'(MM_LATENCY);
    localparam logic [c_K_BITS-1:0] c_K_LAST_LD = c_K_BITS'(SA_SIZE);
    localparam logic [c_K_BITS-1:0] c_K_LAST_MM = c_K_BITS'(c_K_MAX);
    localparam logic [c_K_BITS-1:0] c_K_ONE     = c_K_BITS'(1);

    localparam logic [OPCODE_BITS-1:0] c_OP_IDLE        = OPCODE_BITS'(0);
    localparam logic [OPCODE_BITS-1:0] c_OP_AXI_TO_UB   = OPCODE_BITS'(1);
    localparam logic [OPCODE_BITS-1:0] c_OP_AXI_TO_WB   = OPCODE_BITS'(2);
    localparam logic [OPCODE_BITS-1:0] c_OP_UB_TO_DFIFO = OPCODE_BITS'(3);
    localparam logic [OPCODE_BITS-1:0] c_OP_UB_TO_WFIFO = OPCODE_BITS'(4);
    localparam logic [OPCODE_BITS-1:0] c_OP_MAT_MUL     = OPCODE_BITS'(5);
    localparam logic [OPCODE_BITS-1:0] c_OP_MAT_MUL_ACC = OPCODE_BITS'(6);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_EXEC = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [OPCODE_BITS-1:0] r_op;
    logic [ADDR_BITS-1:0]   r_addra;
    logic [ADDR_BITS-1:0]   r_addrb;
    logic [c_K_BITS-1:0]    r_k;
    logic                   r_err;

    // ------------------------------------------------------------------------
    // Instruction field split
    // ------------------------------------------------------------------------
    logic [OPCODE_BITS-1:0] w_in_op;
    logic [ADDR_BITS-1:0]   w_in_addra;
    logic [ADDR_BITS-1:0]   w_in_addrb;
    logic                   w_in_illegal;

    assign w_in_op      = instruction[INST_BITS-1 -: OPCODE_BITS];
    assign w_in_addra   = instruction[2*ADDR_BITS-1 -: ADDR_BITS];
    assign w_in_addrb   = instruction[ADDR_BITS-1:0];
    assign w_in_illegal = (w_in_op > c_OP_MAT_MUL_ACC);

    // ------------------------------------------------------------------------
    // Handshake and end-of-instruction detection
    // ------------------------------------------------------------------------
    logic [c_K_BITS-1:0] w_k_last;
    logic                w_last;
    logic                w_ready;
    logic                w_accept;

    // Index of the final execute cycle for the latched opcode. IDLE, the
    // AXI writes and illegal opcodes are all single-cycle.
    always_comb begin
        w_k_last = '0;
        case (r_op)
            c_OP_UB_TO_DFIFO,
            c_OP_UB_TO_WFIFO: w_k_last = c_K_LAST_LD;
            c_OP_MAT_MUL,
            c_OP_MAT_MUL_ACC: w_k_last = c_K_LAST_MM;
            default:          w_k_last = '0;
        endcase
    end

    assign w_last = (r_state == S_EXEC) && (r_k == w_k_last);

    // Ready also in the done cycle, which gives zero-bubble back-to-back
    // issue. It is held low while reset is asserted, so nothing can be
    // accepted on the edge that releases reset.
    assign w_ready  = !reset && ((r_state == S_IDLE) || w_last);
    assign w_accept = inst_valid && w_ready;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                if (w_last) begin
                    w_state_nxt = w_accept ? S_EXEC : S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_op    <= '0;
            r_addra <= '0;
            r_addrb <= '0;
            r_k     <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_op    <= w_in_op;
                r_addra <= w_in_addra;
                r_addrb <= w_in_addrb;
                r_k     <= '0;
            end else if (r_state == S_EXEC) begin
                r_k     <= r_k + c_K_ONE;
            end
            if (w_accept && w_in_illegal) begin
                r_err <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Strobe decode
    // ------------------------------------------------------------------------
    // Strobes are decoded only from registered state, so the instruction
    // word has no combinational path to any datapath control.
    logic [c_K_BITS-1:0]  w_k_mm;
    logic [ADDR_BITS-1:0] w_k_addr;
    logic [ADDR_BITS-1:0] w_acc_ofs;
    logic                 w_row_phase;
    logic                 w_fifo_phase;
    logic                 w_acc_phase;

    // Address offsets are reduced to ADDR_BITS, so buffer addresses wrap
    // modulo 2^ADDR_BITS.
    assign w_k_mm       = r_k - c_K_MM;
    assign w_k_addr     = ADDR_BITS'(r_k);
    assign w_acc_ofs    = ADDR_BITS'(w_k_mm);
    assign w_row_phase  = (r_k < c_K_SA);
    // Buffer reads have one cycle of latency, so each FIFO push trails its
    // read by one cycle.
    assign w_fifo_phase = (r_k >= c_K_ONE);
    assign w_acc_phase  = (r_k >= c_K_MM);

    always_comb begin
        inst_ready     = w_ready;
        busy           = (r_state == S_EXEC);
        done           = w_last;
        err            = r_err;
        read_ub        = 1'b0;
        write_ub       = 1'b0;
        read_wb        = 1'b0;
        write_wb       = 1'b0;
        write_acc      = 1'b0;
        data_fifo_en   = 1'b0;
        weight_fifo_en = 1'b0;
        mm_en          = 1'b0;
        acc_en         = 1'b0;
        acc_mode       = 1'b0;
        addr_a         = '0;
        addr_b         = '0;

        if (r_state == S_EXEC) begin
            case (r_op)
                c_OP_AXI_TO_UB: begin
                    write_ub = 1'b1;
                    addr_a   = r_addra;
                end
                c_OP_AXI_TO_WB: begin
                    write_wb = 1'b1;
                    addr_a   = r_addra;
                end
                c_OP_UB_TO_DFIFO: begin
                    if (w_row_phase) begin
                        read_ub = 1'b1;
                        addr_b  = r_addrb + w_k_addr;
                    end
                    data_fifo_en = w_fifo_phase;
                end
                c_OP_UB_TO_WFIFO: begin
                    if (w_row_phase) begin
                        read_wb = 1'b1;
                        addr_b  = r_addrb + w_k_addr;
                    end
                    weight_fifo_en = w_fifo_phase;
                end
                c_OP_MAT_MUL,
                c_OP_MAT_MUL_ACC: begin
                    mm_en    = w_row_phase;
                    acc_mode = (r_op == c_OP_MAT_MUL_ACC);
                    // Results emerge MM_LATENCY cycles after the first
                    // issue, one accumulator row per cycle.
                    if (w_acc_phase) begin
                        write_acc = 1'b1;
                        acc_en    = 1'b1;
                        addr_a    = r_addra + w_acc_ofs;
                    end
                end
                // IDLE and illegal opcodes only occupy one execute cycle.
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sa_inst_decoder.sv
`timescale 1ns/1ps
`default_nettype none
module tb_sa_inst_decoder;

    localparam int OPCODE_BITS = 4;
    localparam int ADDR_BITS   = 8;
    localparam int INST_BITS   = 20;
    localparam int SA_SIZE     = 16;
    localparam int MM_LATENCY  = 18;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 inst_valid = 1'b0;
    logic [INST_BITS-1:0] instruction = '0;
    logic inst_ready, busy, done, err;
    logic read_ub, write_ub, read_wb, write_wb, write_acc;
    logic data_fifo_en, weight_fifo_en, mm_en, acc_en, acc_mode;
    logic [ADDR_BITS-1:0] addr_a, addr_b;

    always #5 clk = ~clk;

    sa_inst_decoder #(
        .OPCODE_BITS(OPCODE_BITS), .ADDR_BITS(ADDR_BITS), .INST_BITS(INST_BITS),
        .SA_SIZE(SA_SIZE), .MM_LATENCY(MM_LATENCY)
    ) dut (
        .clk(clk), .reset(reset), .inst_valid(inst_valid), .instruction(instruction),
        .inst_ready(inst_ready), .busy(busy), .done(done), .err(err),
        .read_ub(read_ub), .write_ub(write_ub), .read_wb(read_wb), .write_wb(write_wb),
        .write_acc(write_acc), .data_fifo_en(data_fifo_en), .weight_fifo_en(weight_fifo_en),
        .mm_en(mm_en), .acc_en(acc_en), .acc_mode(acc_mode),
        .addr_a(addr_a), .addr_b(addr_b)
    );

    // ------------------------------------------------------------------------
    // Reference model: every accepted instruction is expanded into its full
    // per-cycle trace and queued; one entry is consumed per clock.
    // ------------------------------------------------------------------------
    typedef struct packed {
        logic busy, done, ready, err;
        logic read_ub, write_ub, read_wb, write_wb, write_acc;
        logic data_fifo_en, weight_fifo_en, mm_en, acc_en, acc_mode;
    } ctl_t;

    typedef struct {
        ctl_t       c;
        logic       chk_a;
        logic [7:0] a;
        logic       chk_b;
        logic [7:0] b;
    } step_t;

    step_t exp_q[$];
    logic  m_err = 1'b0;
    logic  m_accept = 1'b0;
    int    n_vec = 0;
    int    n_fail = 0;

    function automatic int op_len(input int op);
        if (op == 3 || op == 4) return SA_SIZE + 1;
        if (op == 5 || op == 6) return MM_LATENCY + SA_SIZE;
        return 1;
    endfunction

    function automatic void push_trace(input int op, input int a, input int b);
        step_t s;
        for (int k = 0; k < op_len(op); k++) begin
            s.c = '0; s.chk_a = 1'b0; s.a = '0; s.chk_b = 1'b0; s.b = '0;
            case (op)
                1: begin s.c.write_ub = 1'b1; s.chk_a = 1'b1; s.a = 8'(a); end
                2: begin s.c.write_wb = 1'b1; s.chk_a = 1'b1; s.a = 8'(a); end
                3, 4: begin
                    if (k < SA_SIZE) begin
                        if (op == 3) s.c.read_ub = 1'b1; else s.c.read_wb = 1'b1;
                        s.chk_b = 1'b1;
                        s.b = 8'((b + k) % 256);
                    end
                    if (k >= 1) begin
                        if (op == 3) s.c.data_fifo_en = 1'b1; else s.c.weight_fifo_en = 1'b1;
                    end
                end
                5, 6: begin
                    s.c.mm_en    = (k < SA_SIZE);
                    s.c.acc_mode = (op == 6);
                    if (k >= MM_LATENCY) begin
                        s.c.write_acc = 1'b1;
                        s.c.acc_en    = 1'b1;
                        s.chk_a       = 1'b1;
                        s.a           = 8'((a + k - MM_LATENCY) % 256);
                    end
                end
                default: ;
            endcase
            exp_q.push_back(s);
        end
    endfunction

    task automatic check(input string name);
        ctl_t       e;
        ctl_t       a;
        logic       ea, eb;
        logic [7:0] va, vb;
        int         sz;
        sz = exp_q.size();
        e = '0; ea = 1'b0; eb = 1'b0; va = '0; vb = '0;
        if (sz > 0) begin
            e = exp_q[0].c; ea = exp_q[0].chk_a; va = exp_q[0].a;
            eb = exp_q[0].chk_b; vb = exp_q[0].b;
        end
        e.busy  = (sz > 0);
        e.done  = (sz == 1);
        e.ready = !reset && (sz <= 1);
        e.err   = m_err;
        a = {busy, done, inst_ready, err, read_ub, write_ub, read_wb, write_wb,
             write_acc, data_fifo_en, weight_fifo_en, mm_en, acc_en, acc_mode};
        n_vec++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s ctl (busy,done,rdy,err,rub,wub,rwb,wwb,wacc,dfe,wfe,mm,acc,mode) got=%b want=%b t=%0t",
                     name, a, e, $time);
        end
        if (ea) begin
            n_vec++;
            if (addr_a !== va) begin
                n_fail++;
                $display("FAIL %s addr_a got=%0d want=%0d t=%0t", name, addr_a, va, $time);
            end
        end
        if (eb) begin
            n_vec++;
            if (addr_b !== vb) begin
                n_fail++;
                $display("FAIL %s addr_b got=%0d want=%0d t=%0t", name, addr_b, vb, $time);
            end
        end
    endtask

    task automatic cmp_int(input string name, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    // Advance the model over the coming rising edge using the inputs now
    // applied, then check the DUT at the following falling edge.
    task automatic cycle(input string name);
        logic ready;
        if (reset) begin
            exp_q.delete();
            m_err    = 1'b0;
            m_accept = 1'b0;
        end else begin
            ready    = (exp_q.size() <= 1);
            m_accept = inst_valid && ready;
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            if (m_accept) begin
                push_trace(int'(instruction[19:16]), int'(instruction[15:8]), int'(instruction[7:0]));
                if (instruction[19:16] > 4'd6) m_err = 1'b1;
            end
        end
        @(negedge clk);
        check(name);
    endtask

    task automatic drain(input string name);
        int guard;
        guard = 0;
        inst_valid = 1'b0;
        while (exp_q.size() > 0 && guard < 100) begin
            cycle(name);
            guard++;
        end
        cmp_int({name, "_drain_bound"}, int'(exp_q.size() == 0), 1);
    endtask

    // ------------------------------------------------------------------------
    // Directed table: one instruction each, with hand-computed totals
    // ------------------------------------------------------------------------
    typedef struct {
        int   op, a, b;
        int   len, n_rd, n_fifo, n_mm, n_wr, n_accm;
        logic err;
    } vec_t;

    vec_t tbl[9];

    initial begin
        int  cnt_len, cnt_rd, cnt_fifo, cnt_mm, cnt_wr, cnt_accm, cnt_done, guard, n_acc;
        logic last_err;

        tbl[0] = '{op:0, a:8'h00, b:8'h00, len:1,  n_rd:0,  n_fifo:0,  n_mm:0,  n_wr:0,  n_accm:0,  err:1'b0};
        tbl[1] = '{op:1, a:8'h2A, b:8'h00, len:1,  n_rd:0,  n_fifo:0,  n_mm:0,  n_wr:1,  n_accm:0,  err:1'b0};
        tbl[2] = '{op:2, a:8'h55, b:8'h11, len:1,  n_rd:0,  n_fifo:0,  n_mm:0,  n_wr:1,  n_accm:0,  err:1'b0};
        tbl[3] = '{op:3, a:8'h00, b:250,   len:17, n_rd:16, n_fifo:16, n_mm:0,  n_wr:0,  n_accm:0,  err:1'b0};
        tbl[4] = '{op:4, a:8'h00, b:3,     len:17, n_rd:16, n_fifo:16, n_mm:0,  n_wr:0,  n_accm:0,  err:1'b0};
        tbl[5] = '{op:5, a:4,     b:0,     len:34, n_rd:0,  n_fifo:0,  n_mm:16, n_wr:16, n_accm:0,  err:1'b0};
        tbl[6] = '{op:6, a:250,   b:0,     len:34, n_rd:0,  n_fifo:0,  n_mm:16, n_wr:16, n_accm:34, err:1'b0};
        tbl[7] = '{op:9, a:8'h12, b:8'h34, len:1,  n_rd:0,  n_fifo:0,  n_mm:0,  n_wr:0,  n_accm:0,  err:1'b1};
        tbl[8] = '{op:0, a:8'h00, b:8'h00, len:1,  n_rd:0,  n_fifo:0,  n_mm:0,  n_wr:0,  n_accm:0,  err:1'b1};

        // Reset
        repeat (3) cycle("reset");
        reset = 1'b0;
        cycle("post_reset");

        // Table-driven single instructions
        for (int i = 0; i < 9; i++) begin
            inst_valid  = 1'b1;
            instruction = {4'(tbl[i].op), 8'(tbl[i].a), 8'(tbl[i].b)};
            cycle($sformatf("tbl%0d", i));
            inst_valid = 1'b0;
            cnt_len = 0; cnt_rd = 0; cnt_fifo = 0; cnt_mm = 0; cnt_wr = 0; cnt_accm = 0;
            cnt_done = 0; guard = 0; last_err = 1'b0;
            while (guard < 60) begin
                if (busy) cnt_len++;
                cnt_rd   += int'(read_ub) + int'(read_wb);
                cnt_fifo += int'(data_fifo_en) + int'(weight_fifo_en);
                cnt_mm   += int'(mm_en);
                cnt_wr   += int'(write_ub) + int'(write_wb) + int'(write_acc);
                cnt_accm += int'(acc_mode);
                last_err  = err;
                if (done) begin
                    cnt_done++;
                    break;
                end
                cycle($sformatf("tbl%0d", i));
                guard++;
            end
            cmp_int($sformatf("tbl%0d_done", i), cnt_done, 1);
            cmp_int($sformatf("tbl%0d_len", i), cnt_len, tbl[i].len);
            cmp_int($sformatf("tbl%0d_rd", i), cnt_rd, tbl[i].n_rd);
            cmp_int($sformatf("tbl%0d_fifo", i), cnt_fifo, tbl[i].n_fifo);
            cmp_int($sformatf("tbl%0d_mm", i), cnt_mm, tbl[i].n_mm);
            cmp_int($sformatf("tbl%0d_wr", i), cnt_wr, tbl[i].n_wr);
            cmp_int($sformatf("tbl%0d_accm", i), cnt_accm, tbl[i].n_accm);
            cmp_int($sformatf("tbl%0d_err", i), int'(last_err), int'(tbl[i].err));
            cycle($sformatf("tbl%0d_idle", i));
            cmp_int($sformatf("tbl%0d_ready_after", i), int'(inst_ready), 1);
        end

        // Async reset at MAT_MUL k=5 (also clears the sticky err from above)
        inst_valid  = 1'b1;
        instruction = {4'd5, 8'h10, 8'h00};
        cycle("rst_mm");
        inst_valid = 1'b0;
        repeat (5) cycle("rst_mm");
        cmp_int("rst_mm_en_before", int'(mm_en), 1);
        reset = 1'b1;
        #1;
        exp_q.delete();
        m_err = 1'b0;
        check("rst_async");
        cmp_int("rst_async_mm_en", int'(mm_en), 0);
        cmp_int("rst_async_busy", int'(busy), 0);
        repeat (2) cycle("rst_hold");
        reset = 1'b0;
        cycle("rst_release");
        cmp_int("rst_release_ready", int'(inst_ready), 1);
        cmp_int("rst_release_err", int'(err), 0);

        // MAT_MUL then MAT_MUL_ACC back to back with valid held high
        inst_valid  = 1'b1;
        instruction = {4'd5, 8'd4, 8'd0};
        cycle("b2b");
        instruction = {4'd6, 8'd4, 8'd0};
        guard = 0;
        m_accept = 1'b0;
        while (!m_accept && guard < 60) begin
            cycle("b2b");
            guard++;
        end
        cmp_int("b2b_second_accept_cycle", guard, MM_LATENCY + SA_SIZE);
        inst_valid = 1'b0;
        cmp_int("b2b_second_acc_mode", int'(acc_mode), 1);
        cmp_int("b2b_second_busy", int'(busy), 1);
        drain("b2b");

        // Same MAT_MUL word held for 40 edges: exactly two accepts
        inst_valid  = 1'b1;
        instruction = {4'd5, 8'h20, 8'h00};
        n_acc = 0;
        for (int i = 0; i < 40; i++) begin
            if (inst_valid && inst_ready) n_acc++;
            cycle("hold");
        end
        cmp_int("hold_accepts", n_acc, 2);
        drain("hold");

        // Randomized instruction stream against the model
        for (int n = 0; n < 250; n++) begin
            int r, op, gap;
            r   = int'($urandom_range(0, 19));
            op  = (r < 18) ? (r % 7) : int'($urandom_range(7, 15));
            gap = int'($urandom_range(0, 3));
            inst_valid = 1'b0;
            for (int g = 0; g < gap; g++) cycle("rnd_gap");
            inst_valid  = 1'b1;
            instruction = {4'(op), 8'($urandom), 8'($urandom)};
            guard = 0;
            m_accept = 1'b0;
            while (!m_accept && guard < 60) begin
                cycle("rnd");
                guard++;
            end
            if (!m_accept) cmp_int("rnd_accept_bound", 0, 1);
            inst_valid = 1'b0;
        end
        drain("rnd");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
